// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg -- shared ALU types: multiplier FSM states and result-mux op codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Select codes for the 8:1 ALU result mux; the multiplier feeds the last two.
    localparam logic [2:0] ALU_OP_ADD   = 3'd0;
    localparam logic [2:0] ALU_OP_SUB   = 3'd1;
    localparam logic [2:0] ALU_OP_AND   = 3'd2;
    localparam logic [2:0] ALU_OP_OR    = 3'd3;
    localparam logic [2:0] ALU_OP_XOR   = 3'd4;
    localparam logic [2:0] ALU_OP_SHIFT = 3'd5;
    localparam logic [2:0] ALU_OP_MULLO = 3'd6;
    localparam logic [2:0] ALU_OP_MULHI = 3'd7;

endpackage

`default_nettype wire

// File: rtl/adder_32bit.sv
// ============================================================================
// adder_32bit -- WIDTH-bit adder with carry-out (WIDTH+1-bit sum)
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_32bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

`default_nettype wire

// File: rtl/mult32_seq.sv
// ============================================================================
// mult32_seq -- sequential shift-add multiplier, one bit per cycle.
// Optional signed mode enabled by macro MULT_SIGNED_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult32_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
`ifdef MULT_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t state, state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   upper;
    logic [WIDTH-1:0]   lower;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step_product;
    logic [2*WIDTH-1:0] final_product;
    logic [WIDTH-1:0]   a_load;
    logic [WIDTH-1:0]   b_load;
    logic               accept;
    logic               last_step;

    assign accept    = start && (state != BUSY);
    assign last_step = (cnt == LAST_CNT);

    assign addend = lower[0] ? mcand : '0;

    adder_32bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a   (upper),
        .b   (addend),
        .sum (sum)
    );

    // {carry, upper, lower} shifted right by one after the conditional add
    assign step_product = {sum, lower[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
    logic neg;
    logic neg_load;

    // Multiply magnitudes; the sign is reapplied on the last step so latency is unchanged.
    assign a_load        = (signed_op && ain[WIDTH-1]) ? -ain : ain;
    assign b_load        = (signed_op && bin[WIDTH-1]) ? -bin : bin;
    assign neg_load      = signed_op && (ain[WIDTH-1] ^ bin[WIDTH-1]);
    assign final_product = neg ? -step_product : step_product;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= neg_load;
        end
    end
`else
    assign a_load        = ain;
    assign b_load        = bin;
    assign final_product = step_product;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    state_next = start ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand <= '0;
            upper <= '0;
            lower <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= a_load;
            upper <= '0;
            lower <= b_load;
            cnt   <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
            if (last_step) begin
                {upper, lower} <= final_product;
            end else begin
                {upper, lower} <= step_product;
            end
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);
    assign hi   = upper;
    assign lo   = lower;

endmodule

`default_nettype wire

// File: tb/tb_mult32_seq.sv
// ============================================================================
// tb_mult32_seq -- directed self-checking bench for mult32_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult32_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] ain;
    logic [31:0] bin;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult32_seq #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ain       (ain),
        .bin       (bin),
`ifdef MULT_SIGNED_EN
        .signed_op (signed_op),
`endif
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for done (bounded), checking busy each BUSY cycle; optionally drives
    // a competing start at BUSY edge 'intrude'. Returns edges since acceptance.
    task automatic wait_done(input string tag, input int intrude, output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (n == intrude - 1) begin
                start = 1'b1;
                ain   = 32'd9;
                bin   = 32'd9;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
    endtask

    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el);
        int n;
        ain   = a;
        bin   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(tag, -1, n);
        chk({tag, "_lat"}, 64'(n), 64'd32);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_nbusy"}, 64'(busy), 64'd0);
        chk({tag, "_prod"}, {hi, lo}, {eh, el});
        tick();
        chk({tag, "_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, {hi, lo}, {eh, el});
    endtask

    initial begin
        int n;
        int done_seen;

        rst_n     = 1'b0;
        start     = 1'b0;
        ain       = '0;
        bin       = '0;
        signed_op = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", {hi, lo}, 64'd0);

        // start during reset must be ignored
        ain   = 32'd7;
        bin   = 32'd6;
        start = 1'b1;
        tick();
        chk("rst_start_ign", 64'(busy), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_stay", 64'(busy), 64'd0);

        run_mult("m7x6", 32'd7, 32'd6, 32'h0, 32'h2A);
        run_mult("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_mult("m0xff", 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        run_mult("mffx1", 32'hFFFF_FFFF, 32'h1, 32'h0, 32'hFFFF_FFFF);
        run_mult("m8x2", 32'h8000_0000, 32'h2, 32'h1, 32'h0);
        run_mult("m64k", 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0);

        // Second start mid-operation must not disturb 3*4
        ain   = 32'd3;
        bin   = 32'd4;
        start = 1'b1;
        tick();
        wait_done("ign", 10, n);
        chk("ign_lat", 64'(n), 64'd32);
        chk("ign_prod", {hi, lo}, {32'h0, 32'h0000_000C});
        tick();
        chk("ign_idle", 64'(busy), 64'd0);

        // Reset at BUSY cycle 15 aborts the operation
        ain   = 32'd7;
        bin   = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("abort_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_prod", {hi, lo}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        chk("abort_nodone", 64'(done_seen), 64'd0);

        // Back-to-back: start held in the DONE cycle
        ain   = 32'd7;
        bin   = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("b2b1", -1, n);
        chk("b2b1_lat", 64'(n), 64'd32);
        chk("b2b1_done", 64'(done), 64'd1);
        chk("b2b1_prod", {hi, lo}, {32'h0, 32'h2A});
        ain   = 32'd2;
        bin   = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b2_busy", 64'(busy), 64'd1);
        chk("b2b2_ndone", 64'(done), 64'd0);
        wait_done("b2b2", -1, n);
        chk("b2b2_lat", 64'(n), 64'd32);
        chk("b2b2_prod", {hi, lo}, {32'h0, 32'h0000_000A});
        tick();

`ifdef MULT_SIGNED_EN
        signed_op = 1'b1;
        run_mult("s_m3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_mult("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
        run_mult("s_7x6", 32'd7, 32'd6, 32'h0, 32'h2A);
        signed_op = 1'b0;
        run_mult("u_m3x5", 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult32_seq.md
MULT32_SEQ -- requirements
Module: mult32_seq

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32, operand width in bits; the product is 2*WIDTH bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a multiply; sampled only when the block is idle.
REQ-005 ain  input  WIDTH  multiplicand; captured on the accepting edge.
REQ-006 bin  input  WIDTH  multiplier; captured on the accepting edge.
REQ-007 busy  output  1  high while an iteration sequence is in progress.
REQ-008 done  output  1  one-cycle pulse marking a valid result.
REQ-009 hi  output  WIDTH  upper half of the product; feeds the 8:1 ALU result mux.
REQ-010 lo  output  WIDTH  lower half of the product; feeds the 8:1 ALU result mux.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL latch ain and bin, clear the iteration counter and the upper accumulator, and enter BUSY on the same edge.
REQ-013 In BUSY, each edge SHALL perform one shift-add step: if the accumulator LSB is 1, add the multiplicand to the upper half (WIDTH+1-bit sum), then shift the {carry, upper, lower} register right by one.
REQ-014 BUSY SHALL last exactly WIDTH cycles; the WIDTH-th step SHALL transition to DONE.
REQ-015 done SHALL be 1 only in DONE; DONE SHALL last exactly one cycle, then return to IDLE unless start=1.
REQ-016 With WIDTH=32, done SHALL rise 32 cycles after the start-accepting edge.
REQ-017 hi and lo SHALL hold the final product from entry into DONE until the next accepting edge.
REQ-018 hi and lo SHALL show intermediate accumulator contents during BUSY; consumers qualify them with done.
REQ-019 start SHALL be ignored while in BUSY; the in-flight operation SHALL NOT be disturbed.
REQ-020 busy SHALL equal 1 exactly when the state is BUSY.
REQ-021 Product arithmetic SHALL be exact modulo 2^(2*WIDTH), with no overflow flag.

Reset
REQ-022 rst_n=0 on any edge, including mid-BUSY, SHALL force IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, and SHALL abort the operation.
REQ-023 start SHALL be ignored on any edge where rst_n=0.

Configuration
REQ-024 With MULT_SIGNED_EN defined, the block SHALL have an additional 1-bit input signed_op, captured with the operands.
REQ-025 When signed_op=1, the block SHALL multiply the operand magnitudes and two's-complement negate the product on the final BUSY step if the operand signs differ.
REQ-026 Signed mode SHALL keep the REQ-016 latency unchanged.
REQ-027 Without MULT_SIGNED_EN, signed_op and all sign logic SHALL be absent, and operands SHALL be treated as unsigned.

Structure
REQ-028 The state encoding typedef (IDLE/BUSY/DONE) and the ALU control code constants SHALL live in the shared package alu_pkg.
REQ-029 The WIDTH+1-bit adder SHALL be a separate sub-module, adder_32bit, instantiated once.

Verification
REQ-030 ain=7, bin=6, start pulse -> done after 32 cycles with hi=0x00000000, lo=0x0000002A; busy=1 throughout.
REQ-031 ain=0xFFFFFFFF, bin=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 start with ain=3, bin=4, then start with ain=9, bin=9 at cycle 10 -> the second start is ignored; result lo=0x0000000C.
REQ-033 Drive rst_n=0 at cycle 15 of BUSY -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
REQ-034 start held high in the DONE cycle with new operands 2×5 -> first result (hi=0, lo=0x2A) visible with done, then lo=0x0000000A exactly 32 cycles later.
REQ-035 With MULT_SIGNED_EN defined: signed_op=1, ain=0xFFFFFFFD (-3), bin=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed_op=0 with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
